rr_arb4: RTL and testbench

- Round-robin arbiter that shares one W-bit resource path among four requesters.
- Generates the registered 2-bit select for the 4:1 datapath mux and contains that mux internally.
- Requesters hold req until the resource signals done. A hold-time watchdog prevents one requester from starving the others.
- Sits in front of a shared resource, e.g. a memory or register-file port used by several pipeline stages.

---
 rtl/rr_arb4.sv | 155 +++++++++++++++
 tb/tb_rr_arb4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: four-way round-robin arbiter for one shared W-bit resource path.
// Owns the registered grant/select, the 4:1 payload mux and a hold-time watchdog
// that stops a single requester from monopolising the resource.
module rr_arb4 #(
    parameter int unsigned W        = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic         done,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    input  logic [W-1:0] data3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic         busy,
    output logic [W-1:0] data_out,
    output logic         timeout
);

    // Two-state controller: IDLE waits for any request, BUSY owns the resource.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // A zero MAX_HOLD disables the watchdog entirely; otherwise the grant is
    // forced off once the hold counter reaches MAX_HOLD-1.
    localparam logic       WDOG_EN    = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LIMIT = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic [3:0] holder_mask;
    logic [3:0] arb_req;
    logic [1:0] arb_ptr;
    logic       win_found;
    logic [1:0] win_idx;
    logic       wdog_fire;
    logic       release_c;

    // Release causes for the current holder: completion, withdrawal, or watchdog.
    always_comb begin
        holder_mask = 4'b0001 << sel_q;
        wdog_fire   = WDOG_EN && (state_q == ST_BUSY) && (hold_q == HOLD_LIMIT) && !done;
        release_c   = done || !req[sel_q] || wdog_fire;
    end

    // Arbitration view: in BUSY the holder is masked and the scan starts just past it,
    // so a releasing requester can never win the very next grant.
    always_comb begin
        arb_req = req;
        arb_ptr = ptr_q;
        if (state_q == ST_BUSY) begin
            arb_req = req & ~holder_mask;
            arb_ptr = sel_q + 2'd1;
        end
    end

    // First set request scanning arb_ptr, arb_ptr+1, ... with wrap-around.
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = arb_ptr + i[1:0];
            if (!win_found && arb_req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Next-state logic: grant from IDLE, hold or hand over directly while BUSY.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BUSY;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    hold_d  = 8'd0;
                end
            end
            ST_BUSY: begin
                if (release_c) begin
                    ptr_d     = sel_q + 2'd1;
                    timeout_d = wdog_fire;
                    if (win_found) begin
                        gnt_d  = 4'b0001 << win_idx;
                        sel_d  = win_idx;
                        hold_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = 8'd0;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                hold_d  = 8'd0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            ptr_q     <= 2'b00;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Payload mux: sel[0] picks inside each pair, sel[1] picks the pair.
    always_comb begin
        logic [W-1:0] pair_lo;
        logic [W-1:0] pair_hi;
        pair_lo  = sel_q[0] ? data1 : data0;
        pair_hi  = sel_q[0] ? data3 : data2;
        data_out = sel_q[1] ? pair_hi : pair_lo;
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = (state_q == ST_BUSY);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed scoreboard bench for rr_arb4.
// dut_a runs with a short watchdog, dut_b with the watchdog disabled.
module tb_rr_arb4;

    typedef struct {
        int         dut;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
        logic [2:0] data;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic       done_a, done_b;
    logic [2:0] data0, data1, data2, data3;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b;
    logic [2:0] dout_a, dout_b;
    logic       to_a, to_b;

    logic [2:0] dat [4];
    exp_t       sb [$];
    int         total = 0;
    int         bad   = 0;

    rr_arb4 #(.W(3), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .done(done_a),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .data_out(dout_a), .timeout(to_a)
    );

    rr_arb4 #(.W(3), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .done(done_b),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .data_out(dout_b), .timeout(to_b)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one scoreboard entry against the selected DUT's outputs.
    task automatic checkOutput(input exp_t e);
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
        logic [2:0] d;
        if (e.dut == 0) begin
            g = gnt_a; s = sel_a; b = busy_a; t = to_a; d = dout_a;
        end else begin
            g = gnt_b; s = sel_b; b = busy_b; t = to_b; d = dout_b;
        end
        total++;
        if (g !== e.gnt || s !== e.sel || b !== e.busy || t !== e.timeout || d !== e.data) begin
            bad++;
            $display("[TB] FAIL %s: got gnt=%b sel=%b busy=%b timeout=%b data_out=%0d, expected gnt=%b sel=%b busy=%b timeout=%b data_out=%0d",
                     e.name, g, s, b, t, d, e.gnt, e.sel, e.busy, e.timeout, e.data);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next rising edge.
    task automatic applyStimulus(input int dut, input logic r, input logic [3:0] rq, input logic dn,
                                 input logic [3:0] eg, input logic [1:0] es, input logic eb,
                                 input logic et, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r;
        if (dut == 0) begin
            req_a = rq; done_a = dn; req_b = 4'b0000; done_b = 1'b0;
        end else begin
            req_b = rq; done_b = dn; req_a = 4'b0000; done_a = 1'b0;
        end
        e.dut     = dut;
        e.gnt     = eg;
        e.sel     = es;
        e.busy    = eb;
        e.timeout = et;
        e.data    = dat[es];
        e.name    = nm;
        sb.push_back(e);
    endtask

    // Directed sequence with hand-derived expectations.
    initial begin
        dat[0] = 3'd1; dat[1] = 3'd2; dat[2] = 3'd5; dat[3] = 3'd7;
        data0 = dat[0]; data1 = dat[1]; data2 = dat[2]; data3 = dat[3];
        rst = 1'b1;
        req_a = 4'b0000; done_a = 1'b0;
        req_b = 4'b0000; done_b = 1'b0;

        // reset holds everything clear despite requests
        applyStimulus(0, 1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, "reset_c1");
        applyStimulus(0, 1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, "reset_c2");
        applyStimulus(0, 0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "first_grant");
        // round robin with done each granted cycle
        applyStimulus(0, 0, 4'b1111, 1, 4'b0010, 2'd1, 1, 0, "rr_1");
        applyStimulus(0, 0, 4'b1111, 1, 4'b0100, 2'd2, 1, 0, "rr_2");
        applyStimulus(0, 0, 4'b1111, 1, 4'b1000, 2'd3, 1, 0, "rr_3");
        applyStimulus(0, 0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0, "rr_wrap");
        applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "rr_to_idle");
        // single requester, done in third grant cycle, regrant after one idle cycle
        applyStimulus(0, 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "single_c1");
        applyStimulus(0, 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "single_c2");
        applyStimulus(0, 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "single_c3");
        applyStimulus(0, 0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0, "single_release");
        applyStimulus(0, 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "single_regrant");
        applyStimulus(0, 0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0, "single_release2");
        // withdrawal hands over directly to requester 3
        applyStimulus(0, 0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "wd_grant1");
        applyStimulus(0, 0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0, "wd_handover");
        applyStimulus(0, 0, 4'b1001, 1, 4'b0001, 2'd0, 1, 0, "wd_next0");
        applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "wd_idle");
        applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "done_in_idle");
        // watchdog with MAX_HOLD=4
        applyStimulus(0, 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "wdog_reset");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "wdog_h0_c1");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "wdog_h0_c2");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "wdog_h0_c3");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "wdog_h0_c4");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0010, 2'd1, 1, 1, "wdog_force1");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0, "wdog_h1_c2");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0, "wdog_h1_c3");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0, "wdog_h1_c4");
        applyStimulus(0, 0, 4'b0011, 0, 4'b0001, 2'd0, 1, 1, "wdog_force0");
        applyStimulus(0, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "wdog_idle");
        // mux: walk sel through 0..3, sel retained while idle
        applyStimulus(0, 0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "mux_sel0");
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "mux_idle0");
        applyStimulus(0, 0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "mux_sel1");
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, "mux_idle1");
        applyStimulus(0, 0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "mux_sel2");
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 2'd2, 0, 0, "mux_idle2");
        applyStimulus(0, 0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "mux_sel3");
        applyStimulus(0, 0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "mux_hold3");
        applyStimulus(0, 1, 4'b1000, 0, 4'b0000, 2'd0, 0, 0, "mux_reset_midgrant");
        applyStimulus(0, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "mux_after_reset");

        // watchdog disabled: grant persists well past the 8-bit counter range
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1, 0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "nowdog_hold");
        end
        applyStimulus(1, 0, 4'b0011, 1, 4'b0010, 2'd1, 1, 0, "nowdog_done");
        applyStimulus(1, 0, 4'b0000, 1, 4'b0000, 2'd1, 0, 0, "nowdog_idle");

        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
